// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined integer ALU with valid/ready handshake and sticky overflow error
// Optional macro ALU_SAT_EN: ADD/SUB saturate on signed overflow instead of wrapping.
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; in_a, in_b, in_op, in_tag operation payload
//   out_valid/out_ready  output handshake; out_result, out_tag, out_ovf, out_zero result payload
//   err_clr/err_sticky   clear / sticky flag set when an overflowing result is accepted
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_zero,
    input  logic             err_clr,
    output logic             err_sticky
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [TAG_W-1:0] r_tag;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_res;
    logic [TAG_W-1:0] r_tag2;
    logic             r_ovf;
    logic             r_zero;
    logic             r_err;

    logic             w_s2_load;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_dif;
    logic [SW-1:0]    w_sh;
    logic [WIDTH-1:0] w_sra;
    logic             w_slt;
    logic             w_ovf;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;

    assign w_s2_load = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_load;

    assign w_sum = r_a + r_b;
    assign w_dif = r_a - r_b;
    assign w_sh  = r_b[SW-1:0];
    // Kept as its own net so the arithmetic shift stays signed inside the select chain.
    assign w_sra = $signed(r_a) >>> w_sh;
    assign w_slt = $signed(r_a) < $signed(r_b);

    assign w_ovf = (r_op == 3'd0) ? (r_a[M] == r_b[M] && w_sum[M] != r_a[M]) :
                   (r_op == 3'd1) ? (r_a[M] != r_b[M] && w_dif[M] != r_a[M]) : 1'b0;

    assign w_raw = (r_op == 3'd0) ? w_sum :
                   (r_op == 3'd1) ? w_dif :
                   (r_op == 3'd2) ? (r_a & r_b) :
                   (r_op == 3'd3) ? (r_a | r_b) :
                   (r_op == 3'd4) ? (r_a ^ r_b) :
                   (r_op == 3'd5) ? (r_a << w_sh) :
                   (r_op == 3'd6) ? w_sra :
                   {{M{1'b0}}, w_slt};

`ifdef ALU_SAT_EN
    // Overflow direction follows A's sign: positive A clamps to max, negative A to min.
    assign w_res = w_ovf ? {r_a[M], {M{~r_a[M]}}} : w_raw;
`else
    assign w_res = w_raw;
`endif

    // Payload registers load only on real transfers so idle X inputs never reach outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_tag      <= '0;
        end else begin
            if (in_ready) r_s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                r_a   <= in_a;
                r_b   <= in_b;
                r_op  <= in_op;
                r_tag <= in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_res      <= '0;
            r_tag2     <= '0;
            r_ovf      <= 1'b0;
            r_zero     <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_res  <= w_res;
                r_tag2 <= r_tag;
                r_ovf  <= w_ovf;
                r_zero <= (w_res == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_err <= 1'b0;
        else if (r_s2_valid && out_ready && r_ovf) r_err <= 1'b1;
        else if (err_clr) r_err <= 1'b0;
    end

    assign out_valid  = r_s2_valid;
    assign out_result = r_res;
    assign out_tag    = r_tag2;
    assign out_ovf    = r_ovf;
    assign out_zero   = r_zero;
    assign err_sticky = r_err;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed scoreboard bench for alu_pipe
module tb_alu_pipe;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_tag;
    logic        out_ovf;
    logic        out_zero;
    logic        err_clr;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  t;
        logic        o;
        logic        z;
    } exp_t;

    exp_t q[$];

    alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag),
        .out_ovf(out_ovf), .out_zero(out_zero),
        .err_clr(err_clr), .err_sticky(err_sticky)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] t);
        exp_t   e;
        longint sa, sb, s;
        logic [31:0] r;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        e.o = 1'b0;
        r = '0;
        case (op)
            3'd0, 3'd1: begin
                s = (op == 3'd0) ? sa + sb : sa - sb;
                r = s[31:0];
                e.o = (s > MAXV) || (s < MINV);
`ifdef ALU_SAT_EN
                if (e.o) r = (s > MAXV) ? 32'h7fffffff : 32'h80000000;
`endif
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = a << sh;
            3'd6: begin
                r = a;
                for (int i = 0; i < sh; i++) r = {r[31], r[31:1]};
            end
            default: r = (a[31] != b[31]) ? {31'b0, a[31]} : {31'b0, a < b};
        endcase
        e.r = r;
        e.t = t;
        e.z = (r == 32'h0);
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) begin
                checks++;
                assert (q.size() != 0) else begin
                    errors++;
                    $error("FAIL spurious_output got tag %h exp none", out_tag);
                end
                if (q.size() != 0) begin
                    check("result", out_result, q[0].r);
                    check("tag", {28'b0, out_tag}, {28'b0, q[0].t});
                    check("ovf", {31'b0, out_ovf}, {31'b0, q[0].o});
                    check("zero", {31'b0, out_zero}, {31'b0, q[0].z});
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_tag));
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        in_valid = 0;
        in_a = 'x;
        in_b = 'x;
        in_op = 'x;
        in_tag = 'x;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t);
        bit ok;
        ok = 0;
        in_valid = 1;
        in_op = op;
        in_a = a;
        in_b = b;
        in_tag = t;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL issue_timeout got in_ready=0 exp 1");
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0]  vop[8] = '{3'd1, 3'd1, 3'd6, 3'd5, 3'd7, 3'd7, 3'd2, 3'd4};
    logic [31:0] va[8]  = '{32'h80000000, 32'd5, 32'h80000000, 32'd1, 32'hffffffff, 32'd1,
                            32'hf0f0ff00, 32'h12345678};
    logic [31:0] vb[8]  = '{32'd1, 32'd5, 32'd4, 32'd33, 32'd1, 32'hffffffff,
                            32'h0ff0f0f0, 32'h12345678};

    initial begin
        rst = 1;
        out_ready = 0;
        err_clr = 0;
        idle();
        cyc(2);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_tag", {28'b0, out_tag}, 32'd0);
        check("rst_out_ovf", {31'b0, out_ovf}, 32'd0);
        check("rst_out_zero", {31'b0, out_zero}, 32'd0);
        check("rst_err", {31'b0, err_sticky}, 32'd0);
        rst = 0;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);
        cyc(3);
        check("xidle_out_valid", {31'b0, out_valid}, 32'd0);
        check("xidle_out_result", out_result, 32'd0);
        check("xidle_err", {31'b0, err_sticky}, 32'd0);

        out_ready = 1;
        issue(3'd0, 32'h7fffffff, 32'd1, 4'd1);
        idle();
        check("lat_cycle1", {31'b0, out_valid}, 32'd0);
        cyc(1);
        check("lat_cycle2", {31'b0, out_valid}, 32'd1);
        cyc(1);
        check("err_set", {31'b0, err_sticky}, 32'd1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        check("err_cleared", {31'b0, err_sticky}, 32'd0);

        for (int i = 0; i < 8; i++) issue(vop[i], va[i], vb[i], 4'(i + 2));
        idle();
        cyc(4);
        check("ops_drained", q.size(), 32'd0);

        out_ready = 0;
        in_valid = 1;
        in_op = 3'd0;
        in_a = 32'd100;
        in_b = 32'd1;
        in_tag = 4'd1;
        @(negedge clk);
        check("bp_ready_t1", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_b = 32'd2;
        in_tag = 4'd2;
        @(negedge clk);
        check("bp_ready_t2", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_b = 32'd3;
        in_tag = 4'd3;
        @(negedge clk);
        check("bp_ready_full", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_ready_hold", {31'b0, in_ready}, 32'd0);
        check("bp_buffered", q.size(), 32'd2);
        @(posedge clk);
        #1;
        out_ready = 1;
        issue(3'd0, 32'd100, 32'd3, 4'd3);
        issue(3'd0, 32'd100, 32'd4, 4'd4);
        idle();
        cyc(3);
        check("bp_drained", q.size(), 32'd0);
        check("bp_out_idle", {31'b0, out_valid}, 32'd0);

        issue(3'd0, 32'h7fffffff, 32'd1, 4'd9);
        idle();
        cyc(1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        check("set_wins", {31'b0, err_sticky}, 32'd1);
        err_clr = 1;
        cyc(1);
        err_clr = 0;
        check("clr_alone", {31'b0, err_sticky}, 32'd0);

        issue(3'd1, 32'h80000000, 32'd1, 4'd5);
        idle();
        cyc(3);
        check("pre_rst_err", {31'b0, err_sticky}, 32'd1);
        out_ready = 0;
        issue(3'd2, 32'hffff0000, 32'h0f0f0f0f, 4'd6);
        issue(3'd3, 32'h00000011, 32'h00000100, 4'd7);
        idle();
        check("pre_rst_full", {31'b0, out_valid}, 32'd1);
        check("pre_rst_ready", {31'b0, in_ready}, 32'd0);
        #2;
        rst = 1;
        #1;
        check("async_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_err", {31'b0, err_sticky}, 32'd0);
        check("async_result", out_result, 32'd0);
        q.delete();
        cyc(2);
        rst = 0;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1;
        cyc(6);
        check("no_stale", {31'b0, out_valid}, 32'd0);
        check("final_queue", q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, pipelined integer ALU for the datapath. It is the successor to the single-cycle 3-bit-opcode ALU.
- Operand width is configurable.
- Full opcode space is defined (shifts, signed compare).
- Uses a valid/ready handshake with backpressure, per-result flags, and a sticky error register.
- Sits between the operand-issue stage and the writeback/result FIFO.

Parameters:
- WIDTH, 32: operand/result width in bits, >= 8, power of two.
- TAG_W, 4: width of the sideband tag carried with each operation.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation presented.
- in_ready  out  1  ALU can accept an operation this cycle.
- in_a  in  WIDTH  operand A, two's complement.
- in_b  in  WIDTH  operand B, two's complement.
- in_op  in  3  opcode.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_tag  out  TAG_W  tag of this result.
- out_ovf  out  1  signed overflow for this result.
- out_zero  out  1  out_result == 0.
- err_clr  in  1  clear sticky error.
- err_sticky  out  1  set when any overflowing result is accepted at the output.

Behaviour:
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A-B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SLL: A << B[log2(WIDTH)-1:0].
  - 110 SRA: A >>> B[log2(WIDTH)-1:0], sign-filling.
  - 111 SLT: result 1 if signed A < signed B, else 0.
  - No opcode is invalid. Upper bits of the shift amount are ignored.
- Arithmetic: WIDTH-bit wrap, carry discarded.
- Overflow:
  - ADD: A[msb]==B[msb] and R[msb]!=A[msb].
  - SUB: A[msb]!=B[msb] and R[msb]!=A[msb].
  - out_ovf = 0 for all other ops. SLT never overflows (uses a WIDTH+1 compare).
- Pipeline: two register stages.
  - S1 captures operands/op/tag.
  - S2 holds the computed result, flags and tag. The combinational op evaluates from S1.
  - Latency is 2 cycles from in_valid&&in_ready to out_valid with no backpressure.
  - Throughput is 1 op/cycle.
- Handshake:
  - Transfer occurs when valid&&ready on the same edge.
  - S2 loads when S2 is empty or out_ready.
  - S1 loads when S1 is empty or S1 advances into S2.
  - in_ready = !s1_valid || s2_load. This is combinational from out_ready; no other combinational in->out path.
  - out_* hold stable while out_valid && !out_ready.
  - With out_ready held low, exactly 2 ops are buffered, then in_ready=0. No loss, no duplication, order preserved.
- Sticky error:
  - err_sticky sets on the edge where out_valid&&out_ready&&out_ovf.
  - Clears on err_clr.
  - Set wins over a simultaneous clear.
- Reset: the following are all 0 at reset. Reset mid-operation discards both stages; no partial result is emitted.
  - out_valid, s1_valid, err_sticky.
  - out_result, out_tag, out_ovf.
  - out_zero (reset value 0 despite result 0).
- After reset release: in_ready=1 on the first cycle.
- X on in_a/in_b/in_op/in_tag while in_valid=0 must not propagate to any out_* while out_valid=0 or to err_sticky.

Optional Feature:
Macro ALU_SAT_EN.
- Defined: ADD/SUB saturate on overflow. Positive overflow (A[msb]==0) gives 2^(WIDTH-1)-1; negative overflow gives -2^(WIDTH-1). out_ovf is still 1 and err_sticky still sets. out_zero is computed on the saturated value.
- Undefined: wrapping results as above. No saturation logic is synthesised.

Test Plan:
1. ADD A=0x7FFFFFFF, B=0x00000001, out_ready=1 -> 2 cycles later out_result=0x80000000, out_ovf=1, out_zero=0; err_sticky=1 the next cycle. With ALU_SAT_EN, out_result=0x7FFFFFFF.
2. SUB A=0x80000000, B=0x00000001 -> out_result=0x7FFFFFFF, out_ovf=1 (SAT: 0x80000000). SUB A=5, B=5 -> out_result=0, out_zero=1, out_ovf=0.
3. SRA A=0x80000000, B=4 -> 0xF8000000. SLL A=1, B=33 -> 0x00000002. SLT A=0xFFFFFFFF, B=1 -> 1. SLT A=1, B=0xFFFFFFFF -> 0.
4. Backpressure: issue tags 1,2,3,4 back-to-back with out_ready=0 -> in_ready drops after tags 1,2 are accepted. Raise out_ready for 4 cycles -> outputs tags 1,2,3,4 in order, each once, outputs stable while stalled.
5. err_clr=1 on the same edge an overflowing result is accepted -> err_sticky stays 1. err_clr alone on the next cycle -> err_sticky=0.
6. Assert rst asynchronously with both stages full and out_ready=0 -> out_valid=0 and err_sticky=0 immediately. After release, in_ready=1 and no stale result ever appears.
